// File: rtl/vga_pkg.sv
// Shared types for the VGA overlay path: pixel colour, rectangle attributes,
// and the commit FSM encoding.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned COORD_W  = 10;

   typedef logic [11:0]        rgb_t;
   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   en;
      coord_t x;
      coord_t y;
      coord_t w;
      coord_t h;
      rgb_t   rgb;
   } obj_t;

   typedef enum logic [0:0] {
      StIdle,
      StCommit
   } commit_st_e;

   // One extra bit so that start + length never wraps back into the screen.
   function automatic logic [COORD_W:0] span_end(input coord_t start, input coord_t len);
      return {1'b0, start} + {1'b0, len};
   endfunction

endpackage

// File: rtl/vga_obj_hit.sv
// Combinational rectangle containment test, one per overlay object.
module vga_obj_hit
   import vga_pkg::*;
#(
   parameter int unsigned NUM_OBJ = 4
) (
   input  coord_t                    x_i,
   input  coord_t                    y_i,
   input  obj_t   [NUM_OBJ-1:0]      objs_i,
   output logic   [NUM_OBJ-1:0]      hit_o
);

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      logic [COORD_W:0] x_end;
      logic [COORD_W:0] y_end;
      logic             in_x;
      logic             in_y;

      assign x_end = span_end(objs_i[i].x, objs_i[i].w);
      assign y_end = span_end(objs_i[i].y, objs_i[i].h);

      // Zero width or height gives an empty interval, so it never hits.
      assign in_x = (x_i >= objs_i[i].x) && ({1'b0, x_i} < x_end);
      assign in_y = (y_i >= objs_i[i].y) && ({1'b0, y_i} < y_end);

      assign hit_o[i] = objs_i[i].en & in_x & in_y;
   end

endmodule

// File: rtl/vga_pixel_compositor.sv
// Overlays double-buffered solid rectangles on the background ROM image and
// drives registered RGB plus 2-cycle delay-matched syncs to the DAC.
module vga_pixel_compositor
   import vga_pkg::*;
#(
   parameter int unsigned NUM_OBJ = 4,
   parameter int unsigned RGB_W   = 12,
   parameter int unsigned FCNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              pix_de,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic [RGB_W-1:0]  rom_data,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [2:0]        upd_id,
   input  logic              upd_en,
   input  logic [9:0]        upd_x,
   input  logic [9:0]        upd_y,
   input  logic [9:0]        upd_w,
   input  logic [9:0]        upd_h,
   input  logic [RGB_W-1:0]  upd_rgb,
   output logic [RGB_W-1:0]  vga_rgb,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic [FCNT_W-1:0] frame_cnt
);

   obj_t [NUM_OBJ-1:0] pend_q, pend_d;
   obj_t [NUM_OBJ-1:0] act_q, act_d;
   commit_st_e         state_q, state_d;
   logic               ready_q, ready_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

   coord_t             x1_q, x1_d;
   coord_t             y1_q, y1_d;
   logic               de1_q, de1_d;
   logic               hs1_q, hs1_d;
   logic               vs1_q, vs1_d;

   logic [RGB_W-1:0]   rgb2_q, rgb2_d;
   logic               hs2_q, hs2_d;
   logic               vs2_q, vs2_d;

   logic               upd_fire;
   logic               vs_fall;
   obj_t               upd_obj;
   logic [NUM_OBJ-1:0] hit;
   logic [RGB_W-1:0]   colour;

   assign upd_fire = upd_valid & ready_q;
   // vs1_q doubles as the previous vs_in sample for edge detection.
   assign vs_fall  = vs1_q & ~vs_in;

   assign upd_obj = '{en:  upd_en,
                      x:   upd_x,
                      y:   upd_y,
                      w:   upd_w,
                      h:   upd_h,
                      rgb: rgb_t'(upd_rgb)};

   always_comb begin
      pend_d = pend_q;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
         if (upd_fire && (upd_id == 3'(i))) begin
            pend_d[i] = upd_obj;
         end
      end
   end

   // Commit is taken one cycle after the falling edge so a write accepted in the
   // detection cycle still lands in the pending bank before it is copied.
   always_comb begin
      state_d = state_q;
      ready_d = 1'b1;
      act_d   = act_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         StIdle: begin
            if (vs_fall) begin
               state_d = StCommit;
               ready_d = 1'b0;
            end
         end
         StCommit: begin
            state_d = StIdle;
            act_d   = pend_q;
            fcnt_d  = fcnt_q + FCNT_W'(1);
         end
      endcase
   end

   vga_obj_hit #(
      .NUM_OBJ (NUM_OBJ)
   ) u_obj_hit (
      .x_i    (x1_q),
      .y_i    (y1_q),
      .objs_i (act_q),
      .hit_o  (hit)
   );

   // Lowest index wins, so scan from the top down and let lower hits overwrite.
   always_comb begin
      colour = rom_data;
      for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
         if (hit[i]) begin
            colour = RGB_W'(act_q[i].rgb);
         end
      end
   end

   always_comb begin
      x1_d   = pix_x;
      y1_d   = pix_y;
      de1_d  = pix_de;
      hs1_d  = hs_in;
      vs1_d  = vs_in;
      rgb2_d = de1_q ? colour : '0;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q  <= '0;
         act_q   <= '0;
         state_q <= StIdle;
         ready_q <= 1'b0;
         fcnt_q  <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         rgb2_q  <= '0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
      end else begin
         pend_q  <= pend_d;
         act_q   <= act_d;
         state_q <= state_d;
         ready_q <= ready_d;
         fcnt_q  <= fcnt_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         de1_q   <= de1_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         rgb2_q  <= rgb2_d;
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
      end
   end

   assign upd_ready = ready_q;
   assign vga_rgb   = rgb2_q;
   assign vga_hs    = hs2_q;
   assign vga_vs    = vs2_q;
   assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_vga_pixel_compositor.sv
// Self-checking bench for vga_pixel_compositor: directed scenarios plus a random
// pixel stream, all checked against a rectangle-list model of the overlay.
module tb_vga_pixel_compositor;

   localparam int NUM_OBJ = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic        pix_de = 1'b0;
   logic        hs_in = 1'b1;
   logic        vs_in = 1'b1;
   logic [11:0] rom_data = '0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [2:0]  upd_id = '0;
   logic        upd_en = 1'b0;
   logic [9:0]  upd_x = '0;
   logic [9:0]  upd_y = '0;
   logic [9:0]  upd_w = '0;
   logic [9:0]  upd_h = '0;
   logic [11:0] upd_rgb = '0;
   logic [11:0] vga_rgb;
   logic        vga_hs;
   logic        vga_vs;
   logic [15:0] frame_cnt;

   vga_pixel_compositor #(
      .NUM_OBJ (NUM_OBJ),
      .RGB_W   (12),
      .FCNT_W  (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_de    (pix_de),
      .hs_in     (hs_in),
      .vs_in     (vs_in),
      .rom_data  (rom_data),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_id    (upd_id),
      .upd_en    (upd_en),
      .upd_x     (upd_x),
      .upd_y     (upd_y),
      .upd_w     (upd_w),
      .upd_h     (upd_h),
      .upd_rgb   (upd_rgb),
      .vga_rgb   (vga_rgb),
      .vga_hs    (vga_hs),
      .vga_vs    (vga_vs),
      .frame_cnt (frame_cnt)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending and active rectangle lists.
   int p_en[NUM_OBJ], p_x[NUM_OBJ], p_y[NUM_OBJ], p_w[NUM_OBJ], p_h[NUM_OBJ], p_rgb[NUM_OBJ];
   int a_en[NUM_OBJ], a_x[NUM_OBJ], a_y[NUM_OBJ], a_w[NUM_OBJ], a_h[NUM_OBJ], a_rgb[NUM_OBJ];
   int m_fcnt = 0;
   int rom_mode = 0;

   function automatic logic [11:0] rom_fn(input int x, input int y);
      if (rom_mode == 0) return 12'h0A5;
      return 12'((x * 7 + y * 13) ^ 'h5A3);
   endfunction

   // Background ROM with one cycle of read latency.
   always @(posedge clk) rom_data <= rom_fn(int'(pix_x), int'(pix_y));

   function automatic logic [11:0] exp_pix(input int x, input int y, input bit de);
      if (!de) return 12'h000;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (a_en[i] != 0 && x >= a_x[i] && x < a_x[i] + a_w[i] &&
             y >= a_y[i] && y < a_y[i] + a_h[i]) return 12'(a_rgb[i]);
      end
      return rom_fn(x, y);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_OBJ; i++) begin
         p_en[i] = 0; p_x[i] = 0; p_y[i] = 0; p_w[i] = 0; p_h[i] = 0; p_rgb[i] = 0;
         a_en[i] = 0; a_x[i] = 0; a_y[i] = 0; a_w[i] = 0; a_h[i] = 0; a_rgb[i] = 0;
      end
      m_fcnt = 0;
   endtask

   task automatic model_commit();
      for (int i = 0; i < NUM_OBJ; i++) begin
         a_en[i] = p_en[i]; a_x[i] = p_x[i]; a_y[i] = p_y[i];
         a_w[i] = p_w[i]; a_h[i] = p_h[i]; a_rgb[i] = p_rgb[i];
      end
      m_fcnt = (m_fcnt + 1) % 65536;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_obj(input int id, input int en, input int x, input int y,
                            input int w, input int h, input int rgb);
      bit done = 1'b0;
      bit rdy;
      upd_valid = 1'b1;
      upd_id = 3'(id); upd_en = en[0]; upd_x = 10'(x); upd_y = 10'(y);
      upd_w = 10'(w); upd_h = 10'(h); upd_rgb = 12'(rgb);
      for (int t = 0; t < 8 && !done; t++) begin
         rdy = upd_ready;
         tick();
         if (rdy) done = 1'b1;
      end
      upd_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL write_obj id=%0d: accepted=0 want accepted within 8 cycles", id);
      end else if (id < NUM_OBJ) begin
         p_en[id] = en; p_x[id] = x; p_y[id] = y; p_w[id] = w; p_h[id] = h; p_rgb[id] = rgb;
      end
   endtask

   task automatic check_pix(input int x, input int y, input bit de, input string name);
      logic [11:0] exp;
      exp = exp_pix(x, y, de);
      pix_x = 10'(x); pix_y = 10'(y); pix_de = de;
      tick();
      pix_de = 1'b0;
      tick();
      checks++;
      if (vga_rgb !== exp) begin
         errors++;
         $display("FAIL %s (%0d,%0d): vga_rgb=%h want %h", name, x, y, vga_rgb, exp);
      end
   endtask

   task automatic vsync_commit(input string name);
      int lows = 0;
      vs_in = 1'b0;
      model_commit();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (upd_ready !== 1'b1) lows++;
         if (i == 0 || i == 1) begin
            checks++;
            if (vga_vs !== (i == 0 ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL %s vs_delay cyc%0d: vga_vs=%b want %b", name, i, vga_vs, i != 1);
            end
         end
      end
      vs_in = 1'b1;
      tick();
      tick();
      checks++;
      if (lows != 1) begin
         errors++;
         $display("FAIL %s ready_low: cycles=%0d want 1", name, lows);
      end
      checks++;
      if (frame_cnt !== 16'(m_fcnt)) begin
         errors++;
         $display("FAIL %s frame_cnt: got %0d want %0d", name, frame_cnt, m_fcnt);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({vga_rgb, vga_hs, vga_vs, upd_ready, frame_cnt} !== {12'h000, 3'b110, 16'h0000}) begin
         errors++;
         $display("FAIL %s: rgb=%h hs=%b vs=%b rdy=%b fcnt=%0d want rgb=000 hs=1 vs=1 rdy=0 fcnt=0",
                  name, vga_rgb, vga_hs, vga_vs, upd_ready, frame_cnt);
      end
   endtask

   task automatic test_reset();
      model_reset();
      rom_mode = 0;
      hs_in = 1'b0; pix_x = 10'd5; pix_y = 10'd5; pix_de = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset_hold");
      hs_in = 1'b1;
      rst = 1'b1;
      tick();
      checks++;
      if (vga_rgb !== 12'h000 || upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_cyc1: rgb=%h rdy=%b want rgb=000 rdy=1", vga_rgb, upd_ready);
      end
      tick();
      checks++;
      if (vga_rgb !== 12'h0A5) begin
         errors++;
         $display("FAIL release_cyc2: rgb=%h want 0a5", vga_rgb);
      end
      pix_de = 1'b0;
      check_pix(0, 0, 1'b1, "rom_only_a");
      check_pix(799, 599, 1'b1, "rom_only_b");
      check_pix(300, 200, 1'b0, "blank_de0");
   endtask

   task automatic test_single_obj();
      write_obj(0, 1, 100, 50, 20, 10, 'hF00);
      vsync_commit("commit_obj0");
      rom_mode = 1;
      check_pix(100, 50, 1'b1, "obj0_tl");
      check_pix(119, 59, 1'b1, "obj0_br");
      check_pix(99, 50, 1'b1, "obj0_left_out");
      check_pix(120, 50, 1'b1, "obj0_right_out");
      check_pix(100, 60, 1'b1, "obj0_below_out");
   endtask

   task automatic test_mid_frame();
      write_obj(0, 1, 100, 50, 20, 10, 'h0F0);
      check_pix(100, 50, 1'b1, "midframe_old");
      vsync_commit("commit_midframe");
      check_pix(110, 55, 1'b1, "midframe_new");
   endtask

   task automatic test_priority();
      write_obj(0, 1, 190, 190, 20, 20, 'hF00);
      write_obj(1, 1, 195, 195, 20, 20, 'h00F);
      vsync_commit("commit_overlap");
      check_pix(200, 200, 1'b1, "prio_obj0_wins");
      check_pix(212, 212, 1'b1, "prio_obj1_only");
      write_obj(0, 0, 190, 190, 20, 20, 'hF00);
      vsync_commit("commit_disable0");
      check_pix(200, 200, 1'b1, "prio_obj0_off");
   endtask

   task automatic test_edges();
      write_obj(2, 1, 790, 300, 50, 5, 'h0FF);
      write_obj(3, 1, 400, 400, 0, 10, 'hFF0);
      vsync_commit("commit_edges");
      check_pix(789, 302, 1'b1, "clip_left_out");
      check_pix(790, 302, 1'b1, "clip_first");
      check_pix(799, 302, 1'b1, "clip_last");
      check_pix(400, 400, 1'b1, "w0_never");
      check_pix(400, 405, 1'b1, "w0_never_b");
      write_obj(5, 1, 0, 0, 800, 600, 'hFFF);
      vsync_commit("commit_bad_id");
      check_pix(10, 10, 1'b1, "bad_id_dropped");
   endtask

   task automatic test_hold();
      vs_in = 1'b0;
      model_commit();
      tick();
      write_obj(1, 1, 500, 500, 10, 10, 'h3C3);
      vs_in = 1'b1;
      tick();
      tick();
      checks++;
      if (frame_cnt !== 16'(m_fcnt)) begin
         errors++;
         $display("FAIL hold frame_cnt: got %0d want %0d", frame_cnt, m_fcnt);
      end
      check_pix(505, 505, 1'b1, "hold_not_yet");
      vsync_commit("commit_hold");
      check_pix(505, 505, 1'b1, "hold_committed");
   endtask

   task automatic test_back_to_back();
      logic [11:0] eq[$];
      logic        eh[$];
      logic [11:0] e;
      logic        h;
      int          x, y;
      bit          de, hs;
      for (int i = 0; i < NUM_OBJ; i++) begin
         write_obj(i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 799),
                   $urandom_range(0, 599), $urandom_range(0, 300), $urandom_range(0, 300),
                   $urandom_range(0, 4095));
      end
      vsync_commit("commit_random");
      for (int c = 0; c < 302; c++) begin
         if (c >= 2) begin
            e = eq.pop_front();
            h = eh.pop_front();
            checks++;
            if (vga_rgb !== e || vga_hs !== h || vga_vs !== 1'b1) begin
               errors++;
               $display("FAIL b2b cyc%0d: rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=1",
                        c, vga_rgb, vga_hs, vga_vs, e, h);
            end
         end
         if (c < 300) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 599);
            de = ($urandom_range(0, 4) != 0);
            hs = $urandom_range(0, 1) != 0;
            pix_x = 10'(x); pix_y = 10'(y); pix_de = de; hs_in = hs;
            eq.push_back(exp_pix(x, y, de));
            eh.push_back(hs);
         end else begin
            pix_de = 1'b0;
            hs_in = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      write_obj(0, 1, 300, 300, 40, 40, 'hABC);
      vsync_commit("commit_pre_reset");
      pix_x = 10'd310; pix_y = 10'd310; pix_de = 1'b1;
      tick();
      tick();
      #4;
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midreset_async");
      tick();
      tick();
      check_reset_outputs("midreset_hold");
      rom_mode = 0;
      rst = 1'b1;
      tick();
      tick();
      check_pix(310, 310, 1'b1, "recover_rom");
      check_pix(5, 5, 1'b1, "recover_rom_b");
      vsync_commit("commit_after_reset");
      check_pix(320, 320, 1'b1, "recover_cleared");
   endtask

   initial begin
      test_reset();
      test_single_obj();
      test_mid_frame();
      test_priority();
      test_edges();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
